// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Define FIFO_ARB_BURST_EN to compile in burst locking (up to MAX_BURST beats per grant).
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  input  logic                               full,
  output logic [NUM_REQ-1:0]                 gnt,
  output logic                               wr_en,
  output logic [DATA_WIDTH-1:0]              data_in,
  output logic [$clog2(NUM_REQ)-1:0]         owner,
  output logic                               locked
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(MAX_BURST + 1);

`ifdef FIFO_ARB_BURST_EN
  localparam bit BURST_EN = (MAX_BURST > 1);
`else
  localparam bit BURST_EN = 1'b0;
`endif

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

  logic [0:0]       state;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] burst_cnt;
  logic [CNT_W-1:0] burst_next;

  logic             found;
  logic [IDX_W-1:0] pick;
  logic [IDX_W-1:0] cand;
  logic             gnt_valid;
  logic [IDX_W-1:0] gnt_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_REQ - 1) ? '0 : i + IDX_W'(1);
  endfunction

  // First requesting index at or after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = IDX_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    if (rst_n) begin
      if (state == LOCKED) begin
        gnt_valid = req[owner] && !full;
        gnt_idx   = owner;
      end else begin
        gnt_valid = found && !full;
        gnt_idx   = pick;
      end
    end
  end

  assign gnt        = gnt_valid ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign wr_en      = |gnt;
  assign data_in    = gnt_valid ? req_data[gnt_idx*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign locked     = (state == LOCKED);
  assign burst_next = burst_cnt + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_valid) begin
            if (BURST_EN) begin
              state     <= LOCKED;
              owner     <= gnt_idx;
              burst_cnt <= CNT_W'(1);
            end else begin
              rr_ptr <= next_idx(gnt_idx);
            end
          end
        end
        LOCKED: begin
          // A dropped request ends the burst; a full stall just holds everything.
          if (!req[owner]) begin
            state     <= IDLE;
            rr_ptr    <= next_idx(owner);
            owner     <= '0;
            burst_cnt <= '0;
          end else if (!full) begin
            if (burst_next == CNT_W'(MAX_BURST)) begin
              state     <= IDLE;
              rr_ptr    <= next_idx(owner);
              owner     <= '0;
              burst_cnt <= '0;
            end else begin
              burst_cnt <= burst_next;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed table-driven bench for fifo_wr_arbiter (NUM_REQ=4, MAX_BURST=4, DATA_WIDTH=8).
// Expectations follow FIFO_ARB_BURST_EN the same way the design does.
module tb_fifo_wr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        full;
  logic [3:0]  gnt;
  logic        wr_en;
  logic [7:0]  data_in;
  logic [1:0]  owner;
  logic        locked;

  int total;
  int bad;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       full;
    logic [3:0] gnt;
    logic       chk_reg;
    logic [1:0] owner;
    logic       locked;
  } vec_t;

  vec_t vecs[$];

  localparam logic [3:0] ALL = 4'b1111;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .full(full),
    .gnt(gnt), .wr_en(wr_en), .data_in(data_in), .owner(owner), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic [3:0] rq, input logic f,
                              input logic [3:0] g, input logic ck,
                              input logic [1:0] o, input logic l);
    vec_t v;
    v.rst_n = r; v.req = rq; v.full = f; v.gnt = g;
    v.chk_reg = ck; v.owner = o; v.locked = l;
    vecs.push_back(v);
  endfunction

  function automatic logic [7:0] expData(input logic [3:0] g);
    case (g)
      4'b0001: return 8'hA0;
      4'b0010: return 8'hA1;
      4'b0100: return 8'hA2;
      4'b1000: return 8'hA3;
      default: return 8'h00;
    endcase
  endfunction

  task automatic checkValue(input string name, input int idx,
                            input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s step %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rst_n = v.rst_n;
    req   = v.req;
    full  = v.full;
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    checkValue("gnt", idx, 32'(gnt), 32'(v.gnt));
    checkValue("wr_en", idx, 32'(wr_en), 32'(|v.gnt));
    checkValue("data_in", idx, 32'(data_in), 32'(expData(v.gnt)));
    if (v.chk_reg) begin
      checkValue("owner", idx, 32'(owner), 32'(v.owner));
      checkValue("locked", idx, 32'(locked), 32'(v.locked));
    end
  endtask

  task automatic buildTable();
    // reset gating, then first grant after release
    add(0, ALL, 0, 4'b0000, 0, 0, 0);
    add(0, ALL, 0, 4'b0000, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
`ifdef FIFO_ARB_BURST_EN
    for (int k = 0; k < 3; k++) add(1, ALL, 0, 4'b0001, 1, 0, 1);
    for (int r = 1; r < 4; r++) begin
      add(1, ALL, 0, 4'(1 << r), 1, 0, 0);
      for (int k = 0; k < 3; k++) add(1, ALL, 0, 4'(1 << r), 1, 2'(r), 1);
    end
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
`else
    add(1, ALL, 0, 4'b0010, 1, 0, 0);
    add(1, ALL, 0, 4'b0100, 1, 0, 0);
    add(1, ALL, 0, 4'b1000, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
`endif

    // full stall partway through a burst
    add(0, ALL, 0, 4'b0000, 0, 0, 0);
`ifdef FIFO_ARB_BURST_EN
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 1);
    for (int k = 0; k < 3; k++) add(1, ALL, 1, 4'b0000, 1, 0, 1);
    add(1, ALL, 0, 4'b0001, 1, 0, 1);
    add(1, ALL, 0, 4'b0001, 1, 0, 1);
    add(1, ALL, 0, 4'b0010, 1, 0, 0);
    add(1, ALL, 0, 4'b0010, 1, 1, 1);
`else
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
    add(1, ALL, 0, 4'b0010, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, ALL, 1, 4'b0000, 1, 0, 0);
    add(1, ALL, 0, 4'b0100, 1, 0, 0);
    add(1, ALL, 0, 4'b1000, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
`endif

    // early release of the owner's request
    add(0, ALL, 0, 4'b0000, 0, 0, 0);
`ifdef FIFO_ARB_BURST_EN
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 1);
    add(1, 4'b0100, 0, 4'b0000, 1, 0, 1);
    add(1, 4'b0100, 0, 4'b0100, 1, 0, 0);
    add(1, 4'b0100, 0, 4'b0100, 1, 2, 1);
`else
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
    add(1, ALL, 0, 4'b0010, 1, 0, 0);
    for (int k = 0; k < 3; k++) add(1, 4'b0100, 0, 4'b0100, 1, 0, 0);
`endif

    // single continuous requester
    add(0, ALL, 0, 4'b0000, 0, 0, 0);
    for (int c = 0; c < 12; c++) begin
`ifdef FIFO_ARB_BURST_EN
      if (c % 4 == 0) add(1, 4'b1000, 0, 4'b1000, 1, 0, 0);
      else            add(1, 4'b1000, 0, 4'b1000, 1, 3, 1);
`else
      add(1, 4'b1000, 0, 4'b1000, 1, 0, 0);
`endif
    end

    // reset in the middle of owner 2's burst
    add(0, ALL, 0, 4'b0000, 0, 0, 0);
    add(1, 4'b0100, 0, 4'b0100, 1, 0, 0);
`ifdef FIFO_ARB_BURST_EN
    add(1, 4'b0100, 0, 4'b0100, 1, 2, 1);
    add(0, ALL, 0, 4'b0000, 1, 2, 1);
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 1);
`else
    add(1, 4'b0100, 0, 4'b0100, 1, 0, 0);
    add(0, ALL, 0, 4'b0000, 1, 0, 0);
    add(1, ALL, 0, 4'b0001, 1, 0, 0);
    add(1, ALL, 0, 4'b0010, 1, 0, 0);
`endif
  endtask

  initial begin
    logic [3:0] full_pats [4];
    vec_t       v;
    total    = 0;
    bad      = 0;
    rst_n    = 1'b0;
    req      = '0;
    full     = 1'b0;
    req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

    buildTable();
    $display("[TB] applying %0d table steps", vecs.size());
    foreach (vecs[i]) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      #1;
      checkOutput(vecs[i], i);
    end

    // no grant may ever appear while full is high, whatever is requesting
    full_pats[0] = 4'b0001; full_pats[1] = 4'b0110;
    full_pats[2] = 4'b1111; full_pats[3] = 4'b1000;
    v.rst_n = 0; v.req = ALL; v.full = 0; v.gnt = 0; v.chk_reg = 0; v.owner = 0; v.locked = 0;
    @(negedge clk);
    applyStimulus(v);
    #1;
    checkOutput(v, 1000);
    for (int p = 0; p < 4; p++) begin
      v.rst_n = 1; v.req = full_pats[p]; v.full = 1; v.gnt = 0; v.chk_reg = 1;
      @(negedge clk);
      applyStimulus(v);
      #1;
      checkOutput(v, 1001 + p);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
